draw_rect_ctl: RTL and testbench



---
 rtl/draw_rect_ctl.sv | 137 +++++++++++++
 tb/tb_draw_rect_ctl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_ctl.sv
// Position controller for the rectangle drawer: follows the mouse while the left
// button is held, then falls under constant acceleration to the screen floor.
`timescale 1ns / 1ps

module draw_rect_ctl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int ACCEL    = 1,
  parameter int VMAX     = 16,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAG = 2'd1,
    FALL = 2'd2
  } state_e;

  localparam logic [11:0] X_MAX   = 12'(SCREEN_W - RECT_W);
  localparam logic [11:0] Y_FLOOR = 12'(SCREEN_H - RECT_H);
  localparam logic [11:0] ACCEL_V = 12'(ACCEL);
  localparam logic [11:0] VMAX_V  = 12'(VMAX);
  localparam logic [11:0] INIT_XV = 12'(INIT_X);
  localparam logic [11:0] INIT_YV = 12'(INIT_Y);

  state_e      state_q, state_d;
  logic [11:0] vel_q, vel_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        falling_q, falling_d;
  logic        vblnk_prev_q;

  logic        frame_tick;
  logic [12:0] vel_inc;
  logic [11:0] vel_new;
  logic [12:0] y_sum;
  logic        land;
  logic [11:0] x_clamp;
  logic [11:0] y_clamp;

  // Datapath: all sums are one bit wider than the operands so nothing wraps.
  always_comb begin
    frame_tick = vblnk & ~vblnk_prev_q;
    vel_inc    = {1'b0, vel_q} + {1'b0, ACCEL_V};
    vel_new    = (vel_inc > {1'b0, VMAX_V}) ? VMAX_V : vel_inc[11:0];
    y_sum      = {1'b0, ypos_q} + {1'b0, vel_new};
    land       = (y_sum >= {1'b0, Y_FLOOR});
    x_clamp    = (mouse_xpos > X_MAX)   ? X_MAX   : mouse_xpos;
    y_clamp    = (mouse_ypos > Y_FLOOR) ? Y_FLOOR : mouse_ypos;
  end

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;

    if (mouse_left) begin
      // Grabbing wins over everything, including a landing on the same tick.
      state_d = DRAG;
      if (frame_tick) begin
        xpos_d = x_clamp;
        ypos_d = y_clamp;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        DRAG: begin
          // Release starts the fall from rest; movement begins on the next tick.
          state_d = FALL;
          vel_d   = '0;
        end
        FALL: begin
          if (frame_tick) begin
            if (land) begin
              ypos_d  = Y_FLOOR;
              vel_d   = '0;
              state_d = IDLE;
            end else begin
              ypos_d = y_sum[11:0];
              vel_d  = vel_new;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    falling_d = (state_d == FALL);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // vblnk_prev starts high so a vblnk already high out of reset is not a tick.
      vblnk_prev_q <= 1'b1;
      state_q      <= IDLE;
      vel_q        <= '0;
      xpos_q       <= INIT_XV;
      ypos_q       <= INIT_YV;
      falling_q    <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk;
      state_q      <= state_d;
      vel_q        <= vel_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      falling_q    <= falling_d;
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign falling = falling_q;

  a_x_in_range : assert property (@(posedge clk) disable iff (rst) xpos_q <= X_MAX);
  a_y_in_range : assert property (@(posedge clk) disable iff (rst) ypos_q <= Y_FLOOR);
  a_vel_sat    : assert property (@(posedge clk) disable iff (rst) vel_q <= VMAX_V);
  a_falling    : assert property (@(posedge clk) disable iff (rst) falling_q == (state_q == FALL));

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed self-checking bench for draw_rect_ctl: reset, drag/clamp, falling,
// landing, saturation, re-grab and reset mid-fall.
`timescale 1ns / 1ps

module tb_draw_rect_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        falling;

  int n_vec = 0;
  int n_bad = 0;

  draw_rect_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos),
    .falling    (falling)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One frame: vblnk low for a cycle, then high for several cycles (a long
  // vblnk must still give exactly one tick). Outputs are sampled afterwards.
  task automatic do_tick();
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk) vblnk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drag_to(input logic [11:0] mx, input logic [11:0] my);
    mouse_xpos = mx;
    mouse_ypos = my;
    mouse_left = 1'b1;
    do_tick();
  endtask

  task automatic release_btn();
    @(negedge clk) mouse_left = 1'b0;
    @(negedge clk);
  endtask

  // Cumulative drop from y=0 with ACCEL=1, VMAX=16.
  logic [11:0] sat_exp [20] = '{12'd1, 12'd3, 12'd6, 12'd10, 12'd15, 12'd21, 12'd28,
                                12'd36, 12'd45, 12'd55, 12'd66, 12'd78, 12'd91,
                                12'd105, 12'd120, 12'd136, 12'd152, 12'd168,
                                12'd184, 12'd200};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    vblnk      = 1'b1;
    mouse_left = 1'b1;
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd200;

    // Reset with vblnk high and the button already held.
    repeat (3) @(negedge clk);
    chk("rst_x", xpos, 12'd0);
    chk("rst_y", ypos, 12'd0);
    chk("rst_falling", {11'd0, falling}, 12'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_tick_x", xpos, 12'd0);
    chk("no_tick_y", ypos, 12'd0);

    // First real tick, then a clamped drag.
    do_tick();
    chk("drag_x", xpos, 12'd100);
    chk("drag_y", ypos, 12'd200);
    chk("drag_falling", {11'd0, falling}, 12'd0);
    drag_to(12'd900, 12'd700);
    chk("clamp_x", xpos, 12'd752);
    chk("clamp_y", ypos, 12'd536);
    drag_to(12'd4095, 12'd4095);
    chk("clamp_max_x", xpos, 12'd752);
    chk("clamp_max_y", ypos, 12'd536);

    // Exact landing from y=530.
    drag_to(12'd100, 12'd530);
    chk("pre_fall_y", ypos, 12'd530);
    release_btn();
    chk("fall_start", {11'd0, falling}, 12'd1);
    do_tick();
    chk("fall1_y", ypos, 12'd531);
    chk("fall1_falling", {11'd0, falling}, 12'd1);
    do_tick();
    chk("fall2_y", ypos, 12'd533);
    do_tick();
    chk("fall3_y", ypos, 12'd536);
    chk("land_falling", {11'd0, falling}, 12'd0);
    chk("land_x", xpos, 12'd100);
    do_tick();
    chk("idle_y", ypos, 12'd536);

    // Overshoot clamped to floor from y=534.
    drag_to(12'd100, 12'd534);
    release_btn();
    do_tick();
    chk("ovr1_y", ypos, 12'd535);
    do_tick();
    chk("ovr2_y", ypos, 12'd536);
    chk("ovr_falling", {11'd0, falling}, 12'd0);
    do_tick();
    chk("ovr_idle_y", ypos, 12'd536);

    // Already on the floor when released: lands on the first tick.
    drag_to(12'd0, 12'd600);
    release_btn();
    chk("floor_fall", {11'd0, falling}, 12'd1);
    do_tick();
    chk("floor_land_y", ypos, 12'd536);
    chk("floor_land_falling", {11'd0, falling}, 12'd0);

    // Release in the same cycle as a tick: no movement yet.
    drag_to(12'd200, 12'd300);
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk) begin
      vblnk      = 1'b1;
      mouse_left = 1'b0;
    end
    @(negedge clk);
    chk("rel_tick_y", ypos, 12'd300);
    chk("rel_tick_falling", {11'd0, falling}, 12'd1);
    do_tick();
    chk("rel_next_y", ypos, 12'd301);

    // Velocity saturation from y=0.
    drag_to(12'd100, 12'd0);
    release_btn();
    for (int i = 0; i < 20; i++) begin
      do_tick();
      chk($sformatf("sat%0d_y", i + 1), ypos, sat_exp[i]);
    end
    chk("sat_x", xpos, 12'd100);
    chk("sat_falling", {11'd0, falling}, 12'd1);

    // Re-grab on a tick cycle mid-fall.
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk) begin
      vblnk      = 1'b1;
      mouse_left = 1'b1;
      mouse_xpos = 12'd10;
      mouse_ypos = 12'd10;
    end
    @(negedge clk);
    chk("regrab_x", xpos, 12'd10);
    chk("regrab_y", ypos, 12'd10);
    chk("regrab_falling", {11'd0, falling}, 12'd0);

    // Velocity restarts from zero after the re-grab.
    release_btn();
    do_tick();
    chk("refall_y", ypos, 12'd11);

    // Reset mid-fall.
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midrst_x", xpos, 12'd0);
    chk("midrst_y", ypos, 12'd0);
    chk("midrst_falling", {11'd0, falling}, 12'd0);
    rst = 1'b0;
    do_tick();
    chk("post_rst_idle_y", ypos, 12'd0);
    chk("post_rst_idle_falling", {11'd0, falling}, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
